// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - MIPS E-stage multiply/divide unit with HI/LO and start/busy handshake.
// Optional MDU_MADD_EN enables madd/maddu (op 7/8) accumulating into {HI,LO}.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_req,
  input  logic        i_mf_sel,
  output logic        o_busy,
  output logic [31:0] o_HI,
  output logic [31:0] o_LO,
  output logic [31:0] o_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;

  logic        is_signed, is_mul, is_mad, is_div, launch;
  logic [63:0] a_ext, b_ext, prod, mult_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quo, rem;

  always_comb begin
    is_signed = (i_op == OP_MULT) || (i_op == OP_DIV) || (i_op == OP_MADD);
    is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
    is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
`ifdef MDU_MADD_EN
    is_mad    = (i_op == OP_MADD) || (i_op == OP_MADDU);
`else
    is_mad    = 1'b0;
`endif
    // The low 64 bits of an extended product are correct for both signednesses.
    a_ext = is_signed ? {{32{i_A[31]}}, i_A} : {32'b0, i_A};
    b_ext = is_signed ? {{32{i_B[31]}}, i_B} : {32'b0, i_B};
    prod  = a_ext * b_ext;
`ifdef MDU_MADD_EN
    mult_res = is_mad ? ({hi_q, lo_q} + prod) : prod;
`else
    mult_res = prod;
`endif
    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_neg = is_signed && i_A[31];
    b_neg = is_signed && i_B[31];
    a_mag = a_neg ? -i_A : i_A;
    b_mag = (i_B == 32'd0) ? 32'd1 : (b_neg ? -i_B : i_B);
    uq    = a_mag / b_mag;
    ur    = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? -uq : uq;
    rem   = a_neg ? -ur : ur;
  end

  assign launch = i_start && (is_mul || is_mad || is_div) && !i_req && !busy_q;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    if (busy_q) begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1 && pend_wr_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (launch) begin
      if (is_div) begin
        cnt_d     = 5'(DIV_CYCLES);
        pend_d    = {rem, quo};
        pend_wr_d = (i_B != 32'd0);
      end else begin
        cnt_d     = 5'(MULT_CYCLES);
        pend_d    = mult_res;
        pend_wr_d = 1'b1;
      end
    end else if (!i_req) begin
      if (i_op == OP_MTHI) hi_d = i_A;
      if (i_op == OP_MTLO) lo_d = i_A;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= (cnt_d != 5'd0);
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign o_busy = busy_q;
  assign o_HI   = hi_q;
  assign o_LO   = lo_q;
  assign o_out  = i_mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against a behavioural model.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst, start, req, sel;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op), .i_A(a), .i_B(b),
    .i_req(req), .i_mf_sel(sel), .o_busy(busy), .o_HI(hi), .o_LO(lo), .o_out(out)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] res, output bit wr);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    wr = 1'b1;
    res = {m_hi, m_lo};
    case (o)
      4'd1: res = 64'(sx * sy);
      4'd2: res = ux * uy;
      4'd3: if (y == 0) wr = 1'b0; else begin q = sx / sy; r = sx % sy; res = {r[31:0], q[31:0]}; end
      4'd4: if (y == 0) wr = 1'b0; else res = {32'(ux % uy), 32'(ux / uy)};
      4'd7: res = {m_hi, m_lo} + 64'(sx * sy);
      4'd8: res = {m_hi, m_lo} + ux * uy;
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic launch_wait(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                             output int nb, output bit held, output logic [31:0] rh, output logic [31:0] rl);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; held = 1'b1; nb = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    while (busy && nb < 40) begin
      nb++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk); #1;
    end
    rh = hi; rl = lo;
  endtask

  task automatic mt_write(input logic [3:0] o, input logic [31:0] x);
    op = o; a = x;
    @(posedge clk); #1;
    op = 4'd0;
    if (o == 4'd5) m_hi = x; else m_lo = x;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; req = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, hi, lo, out} !== 97'd0) begin
      errors++; $display("FAIL reset_state busy=%b hi=%h lo=%h out=%h exp all zero", busy, hi, lo, out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo();
    op = 4'd5; a = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL mthi_req got %h exp %h", hi, m_hi); end
    req = 1'b0;
    @(posedge clk); #1;
    op = 4'd0; m_hi = 32'h12345678;
    checks++;
    if (hi !== 32'h12345678) begin errors++; $display("FAIL mthi got %h exp 12345678", hi); end
    sel = 1'b1; #1;
    checks++;
    if (out !== 32'h12345678) begin errors++; $display("FAIL mf_hi got %h exp 12345678", out); end
    sel = 1'b0; #1;
    checks++;
    if (out !== m_lo) begin errors++; $display("FAIL mf_lo got %h exp %h", out, m_lo); end
  endtask

  task automatic test_mult();
    int nb; bit held; logic [31:0] rh, rl;
    launch_wait(4'd1, 32'hFFFFFFFE, 32'h3, nb, held, rh, rl);
    checks++;
    if (nb !== MC || !held) begin errors++; $display("FAIL mult_busy cycles=%0d held=%0b exp %0d,1", nb, held, MC); end
    checks++;
    if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFA) begin errors++; $display("FAIL mult_res got %h%h exp FFFFFFFFFFFFFFFA", rh, rl); end
    launch_wait(4'd2, 32'hFFFFFFFE, 32'h3, nb, held, rh, rl);
    checks++;
    if (nb !== MC) begin errors++; $display("FAIL multu_busy got %0d exp %0d", nb, MC); end
    checks++;
    if ({rh, rl} !== 64'h00000002_FFFFFFFA) begin errors++; $display("FAIL multu_res got %h%h exp 00000002FFFFFFFA", rh, rl); end
    m_hi = rh; m_lo = rl;
  endtask

  task automatic test_div();
    int nb; bit held; logic [31:0] rh, rl;
    launch_wait(4'd3, 32'hFFFFFFF9, 32'h2, nb, held, rh, rl);
    checks++;
    if (nb !== DC || !held) begin errors++; $display("FAIL div_busy cycles=%0d held=%0b exp %0d,1", nb, held, DC); end
    checks++;
    if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_res got %h%h exp FFFFFFFFFFFFFFFD", rh, rl); end
    mt_write(4'd5, 32'h11);
    mt_write(4'd6, 32'h22);
    launch_wait(4'd4, 32'h7, 32'h0, nb, held, rh, rl);
    checks++;
    if (nb !== DC) begin errors++; $display("FAIL div0_busy got %0d exp %0d", nb, DC); end
    checks++;
    if ({rh, rl} !== 64'h00000011_00000022) begin errors++; $display("FAIL div0_keep got %h%h exp 0000001100000022", rh, rl); end
    launch_wait(4'd3, 32'h80000000, 32'hFFFFFFFF, nb, held, rh, rl);
    checks++;
    if ({rh, rl} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf got %h%h exp 0000000080000000", rh, rl); end
    m_hi = rh; m_lo = rl;
  endtask

  task automatic test_req_and_unknown();
    for (int o = 0; o < 16; o++) begin
      if (o >= 1 && o <= 4) begin
        req = 1'b1; start = 1'b1; op = 4'(o);
      end else if (o == 0 || o >= 9) begin
        req = 1'b0; start = 1'b1; op = 4'(o);
      end else continue;
      a = $urandom; b = $urandom | 32'h1;
      @(posedge clk); #1;
      start = 1'b0; req = 1'b0; op = 4'd0;
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++; $display("FAIL no_launch op=%0d busy=%b hi=%h lo=%h exp 0 %h %h", o, busy, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_ignored_while_busy();
    int nb;
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      start = (nb == 3);
      op    = (nb == 3) ? 4'd1 : (nb == 4) ? 4'd6 : 4'd0;
      a     = (nb == 4) ? 32'h5 : 32'h9;
      b     = 32'h9;
      @(posedge clk); #1;
    end
    start = 1'b0; op = 4'd0;
    checks++;
    if (nb !== DC) begin errors++; $display("FAIL ignore_busy got %0d exp %0d", nb, DC); end
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL ignore_res got %h%h exp 000000020000000E", hi, lo); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_madd();
    int nb; bit held; logic [31:0] rh, rl;
    mt_write(4'd5, 32'h0);
    mt_write(4'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    launch_wait(4'd7, 32'h2, 32'h3, nb, held, rh, rl);
    checks++;
    if (nb !== MC) begin errors++; $display("FAIL madd_busy got %0d exp %0d", nb, MC); end
    checks++;
    if ({rh, rl} !== 64'h00000001_00000005) begin errors++; $display("FAIL madd_res got %h%h exp 0000000100000005", rh, rl); end
    m_hi = rh; m_lo = rl;
`else
    launch_wait(4'd7, 32'h2, 32'h3, nb, held, rh, rl);
    checks++;
    if (nb !== 0 || {rh, rl} !== {m_hi, m_lo}) begin
      errors++; $display("FAIL madd_off busy=%0d got %h%h exp 0 %h%h", nb, rh, rl, m_hi, m_lo);
    end
`endif
  endtask

  task automatic test_random();
    int nb; bit held, wr; logic [31:0] rh, rl, x, y; logic [63:0] res; logic [3:0] o; int exp_nb;
    for (int i = 0; i < 30; i++) begin
`ifdef MDU_MADD_EN
      o = 4'($urandom_range(1, 8));
`else
      o = 4'($urandom_range(1, 6));
`endif
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (o == 4'd5 || o == 4'd6) begin
        start = 1'($urandom_range(0, 1));
        mt_write(o, x);
        start = 1'b0;
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL rnd_mt op=%0d got %h%h exp %h%h", o, hi, lo, m_hi, m_lo); end
      end else begin
        model(o, x, y, res, wr);
        exp_nb = (o == 4'd3 || o == 4'd4) ? DC : MC;
        launch_wait(o, x, y, nb, held, rh, rl);
        if (wr) begin m_hi = res[63:32]; m_lo = res[31:0]; end
        checks++;
        if (nb !== exp_nb || !held || {rh, rl} !== {m_hi, m_lo}) begin
          errors++;
          $display("FAIL rnd_op op=%0d a=%h b=%h busy=%0d held=%0b got %h%h exp %0d %h%h", o, x, y, nb, held, rh, rl, exp_nb, m_hi, m_lo);
        end
      end
    end
  endtask

  task automatic test_reset_mid_mult();
    bit ok;
    mt_write(4'd5, 32'hA5A5A5A5);
    start = 1'b1; op = 4'd1; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_no_update busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_req_and_unknown();
    test_ignored_while_busy();
    test_madd();
    test_random();
    test_reset_mid_mult();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
